// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with parallel load, configurable step and wrap or clamp at the bounds.
// count/wrap/load_err are registered; at_zero/at_max decode the registered count.
module mod_updown_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 200,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ud,
    input  logic             lc,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             at_zero,
    output logic             at_max,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH-1:0] step_eff;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH:0]   sum_down_wrap;

    // An out-of-range step is clamped to MODULUS-1 so every result stays in range.
    assign step_eff      = ({1'b0, step} >= MOD_W) ? MAX_V : step;
    assign sum_up        = {1'b0, count_q} + {1'b0, step_eff};
    assign sum_down_wrap = {1'b0, count_q} + MOD_W - {1'b0, step_eff};

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (enable) begin
            if (lc) begin
                if ({1'b0, load_val} >= MOD_W) begin
                    count_d    = MAX_V;
                    load_err_d = 1'b1;
                end else begin
                    count_d = load_val;
                end
            end else if (!ud) begin
                if (sum_up >= MOD_W) begin
                    wrap_d  = 1'b1;
                    count_d = SATURATE ? MAX_V : WIDTH'(sum_up - MOD_W);
                end else begin
                    count_d = sum_up[WIDTH-1:0];
                end
            end else begin
                if (step_eff <= count_q) begin
                    count_d = count_q - step_eff;
                end else begin
                    wrap_d  = 1'b1;
                    count_d = SATURATE ? '0 : sum_down_wrap[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;
    assign at_zero  = (count_q == '0);
    assign at_max   = (count_q == MAX_V);

endmodule
